// File: rtl/dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_pkg
// Description : Shared types and helpers for the DNN datapath blocks:
//               accumulator state encoding and signed saturation.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_pkg;

    // Dot-product accumulator control states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    // The caller truncates the result to w bits.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] value,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree
// Description : Registered reduction of z signed lanes. Lanes are captured on
//               acceptance, then their full-precision sum is registered one
//               cycle later together with the valid and last tags.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree #(
    parameter int z     = 4,
    parameter int width = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    input  logic                                in_last,
    input  logic signed [width-1:0]             p [z-1:0],
    output logic                                out_valid,
    output logic                                out_last,
    output logic signed [width+$clog2(z)-1:0]   out_sum
);

    localparam int c_sum_w = width + $clog2(z);

    logic signed [width-1:0]   p_q [z-1:0];
    logic signed [width-1:0]   p_d [z-1:0];
    logic                      v0_q, v0_d;
    logic                      l0_q, l0_d;
    logic                      v1_q, v1_d;
    logic                      l1_q, l1_d;
    logic signed [c_sum_w-1:0] sum_q, sum_d;
    logic signed [c_sum_w-1:0] w_tree;

    // Next-state: capture lanes only on acceptance, reduce captured lanes
    always_comb begin
        p_d    = p_q;
        if (in_valid) begin
            p_d = p;
        end
        v0_d   = in_valid;
        l0_d   = in_valid & in_last;

        w_tree = '0;
        for (int i = 0; i < z; i++) begin
            w_tree = w_tree + c_sum_w'(p_q[i]);
        end

        v1_d  = v0_q;
        l1_d  = v0_q & l0_q;
        sum_d = v0_q ? w_tree : sum_q;
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q   <= '{default: '0};
            v0_q  <= 1'b0;
            l0_q  <= 1'b0;
            v1_q  <= 1'b0;
            l1_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            p_q   <= p_d;
            v0_q  <= v0_d;
            l0_q  <= l0_d;
            v1_q  <= v1_d;
            l1_q  <= l1_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = v1_q;
    assign out_last  = l1_q;
    assign out_sum   = sum_q;

endmodule
`default_nettype wire

// File: rtl/dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : dot_accumulator
// Description : Accumulates beats of z signed products into one saturated
//               dot product over 'beats' accepted beats, with a valid/ready
//               result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_accumulator
    import dnn_pkg::*;
#(
    parameter int z        = 4,
    parameter int width    = 12,
    parameter int int_bits = 3,
    parameter int beats    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [width-1:0] p [z-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [width-1:0] out_sum
);

    localparam int c_sum_w = width + $clog2(z);
    localparam int c_acc_w = width + $clog2(z * beats);
    localparam int c_cnt_w = (beats > 1) ? $clog2(beats) : 1;

    // The fixed-point split only constrains the format; arithmetic is integer
    if (int_bits < 0 || int_bits > width - 1) begin : g_bad_int_bits
        $error("dot_accumulator: int_bits must lie in 0..width-1");
    end

    state_t                    state_q, state_d;
    logic [c_cnt_w-1:0]        cnt_q, cnt_d;
    logic signed [c_acc_w-1:0] acc_q, acc_d;
    logic signed [width-1:0]   out_sum_q, out_sum_d;

    logic                      w_accept;
    logic                      w_beat_last;
    logic                      s1_valid;
    logic                      s1_last;
    logic signed [c_sum_w-1:0] s1_sum;
    logic signed [c_acc_w-1:0] w_fold;

    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == OUT);
    assign out_sum     = out_sum_q;
    assign w_accept    = in_valid & in_ready;
    assign w_beat_last = (cnt_q == c_cnt_w'(beats - 1));

    adder_tree #(
        .z     (z),
        .width (width)
    ) u_adder_tree (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w_accept),
        .in_last   (w_beat_last),
        .p         (p),
        .out_valid (s1_valid),
        .out_last  (s1_last),
        .out_sum   (s1_sum)
    );

    // Next-state: beat counting, folding stage-1 sums and the result handshake
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_sum_d = out_sum_q;
        w_fold    = acc_q + c_acc_w'(s1_sum);

        if (w_accept) begin
            cnt_d = w_beat_last ? '0 : cnt_q + 1'b1;
        end

        // Non-last entries grow the accumulator; the last one closes the product
        if (s1_valid) begin
            if (s1_last) begin
                out_sum_d = width'(saturate(64'(w_fold), width));
                acc_d     = '0;
            end else begin
                acc_d     = w_fold;
            end
        end

        case (state_q)
            ACCUM: if (w_accept && w_beat_last) state_d = DRAIN;
            DRAIN: if (s1_valid && s1_last)     state_d = OUT;
            OUT:   if (out_ready)               state_d = ACCUM;
            default:                            state_d = ACCUM;
        endcase
    end

    // Control and accumulator registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ACCUM;
            cnt_q     <= '0;
            acc_q     <= '0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            out_sum_q <= out_sum_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_accumulator
// Description : Directed and randomized self-checking bench for
//               dot_accumulator against a dot-product reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_accumulator;

    localparam int Z     = 4;
    localparam int W     = 12;
    localparam int IB    = 3;
    localparam int BEATS = 2;
    localparam int LW    = W * Z;

    logic                clk       = 1'b0;
    logic                reset     = 1'b1;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic                in_ready;
    logic                out_valid;
    logic signed [W-1:0] p [Z-1:0];
    logic signed [W-1:0] out_sum;

    int total = 0;
    int bad   = 0;

    // Reference model state: running sum of products of the open dot product
    longint      partial = 0;
    int          beat_no = 0;
    logic [W-1:0] exp_q[$];

    dot_accumulator #(
        .z        (Z),
        .width    (W),
        .int_bits (IB),
        .beats    (BEATS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] sat_ref(input longint v);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        r  = (v > hi) ? hi : ((v < lo) ? lo : v);
        return W'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        partial = 0;
        beat_no = 0;
        exp_q.delete();
    endtask

    // Present one beat, wait for acceptance, then record it in the model
    task automatic send_beat(input logic [LW-1:0] lanes);
        int n;
        logic signed [W-1:0] lane;
        n = 0;
        for (int i = 0; i < Z; i++) p[i] = lanes[i*W +: W];
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("in_ready_timeout", {{(W-1){1'b0}}, in_ready}, 1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < Z; i++) begin
            lane    = lanes[i*W +: W];
            partial = partial + longint'(lane);
        end
        beat_no++;
        if (beat_no == BEATS) begin
            exp_q.push_back(sat_ref(partial));
            partial = 0;
            beat_no = 0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {{(W-1){1'b0}}, out_valid}, 1);
    endtask

    // Check the pending result against the model and consume it
    task automatic get_result(input string tag, input int hold);
        logic [W-1:0] e;
        wait_valid(tag);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_sum"}, out_sum, e);
        for (int i = 0; i < hold; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_release"}, {{(W-1){1'b0}}, out_valid}, 0);
    endtask

    function automatic logic [LW-1:0] splat(input logic [W-1:0] v);
        logic [LW-1:0] r;
        for (int i = 0; i < Z; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [LW-1:0] rand_lanes();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[LW-1:0];
    endfunction

    initial begin
        logic [LW-1:0] b0;
        logic [LW-1:0] b1;
        logic [LW-1:0] alt;
        logic [W-1:0]  e;

        for (int i = 0; i < Z; i++) p[i] = '0;

        // Reset state
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
        chk("rst_in_ready",  {{(W-1){1'b0}}, in_ready},  1);
        chk("rst_out_sum",   out_sum, 12'h000);

        // Two beats of ones with exact latency
        send_beat(splat(12'h001));
        send_beat(splat(12'h001));
        chk("lat_k0_valid", {{(W-1){1'b0}}, out_valid}, 0);
        chk("drain_in_ready", {{(W-1){1'b0}}, in_ready}, 0);
        step();
        chk("lat_k1_valid", {{(W-1){1'b0}}, out_valid}, 0);
        step();
        chk("lat_k2_valid", {{(W-1){1'b0}}, out_valid}, 1);
        chk("ones_const", out_sum, 12'h008);
        get_result("ones", 0);

        // Positive and negative saturation
        send_beat(splat(12'h100));
        send_beat(splat(12'h100));
        get_result("sat_pos", 0);
        send_beat(splat(12'h800));
        send_beat(splat(12'h800));
        get_result("sat_neg", 0);

        // Extremes cancelling to a small negative value
        alt = {12'h800, 12'h7ff, 12'h800, 12'h7ff};
        send_beat(alt);
        send_beat(alt);
        wait_valid("alt");
        chk("alt_const", out_sum, 12'hffc);
        get_result("alt", 0);

        // Backpressure in OUT while new beats are offered
        send_beat(rand_lanes());
        send_beat(rand_lanes());
        wait_valid("bp");
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < Z; j++) p[j] = W'($urandom());
            in_valid = 1'b1;
            step();
            chk("bp_hold_sum",   out_sum, e);
            chk("bp_in_ready",   {{(W-1){1'b0}}, in_ready},  0);
            chk("bp_hold_valid", {{(W-1){1'b0}}, out_valid}, 1);
        end
        in_valid = 1'b0;
        get_result("bp", 0);
        send_beat(splat(12'h003));
        send_beat(splat(12'h002));
        get_result("after_bp", 0);

        // Reset after the first beat discards the partial sum
        send_beat(splat(12'h055));
        reset = 1'b1;
        #2;
        chk("rst_mid_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
        step();
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid_no_valid", {{(W-1){1'b0}}, out_valid}, 0);
        end
        send_beat(splat(12'h001));
        send_beat(splat(12'h001));
        wait_valid("rst_mid");
        chk("rst_mid_const", out_sum, 12'h008);
        get_result("rst_mid", 0);

        // Reset while a result waits in OUT discards it
        send_beat(splat(12'h010));
        send_beat(splat(12'h010));
        wait_valid("rst_out");
        reset = 1'b1;
        #2;
        chk("rst_out_drop", {{(W-1){1'b0}}, out_valid}, 0);
        step();
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_out_no_valid", {{(W-1){1'b0}}, out_valid}, 0);
        end
        chk("rst_out_sum", out_sum, 12'h000);

        // Same beats with in_valid toggling, then back to back
        b0 = rand_lanes();
        b1 = rand_lanes();
        send_beat(b0);
        step();
        send_beat(b1);
        step();
        get_result("toggle", 0);
        send_beat(b0);
        send_beat(b1);
        get_result("b2b", 0);

        // Randomized dot products with random gaps and consumer delay
        for (int t = 0; t < 12; t++) begin
            for (int b = 0; b < BEATS; b++) begin
                send_beat(rand_lanes());
                repeat ($urandom_range(0, 2)) step();
            end
            get_result("rand", $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
